// File: rtl/aes_v2_mix_size_pkg.sv
// ---------------------------------------------------------------------------
// aes_v2_mix_size_pkg
// Shared definitions for the size-optimised AES MixColumns/InvMixColumns unit:
//   AES_POLY     - reduction constant of GF(2^8) modulo x^8+x^4+x^3+x+1
//   mix_state_t  - byte-serial sequencer state (S0..S3 = output byte index)
//   xtime()      - multiply-by-2 in GF(2^8), the only arithmetic primitive
// ---------------------------------------------------------------------------
package aes_v2_mix_size_pkg;

    localparam logic [7:0] AES_POLY = 8'h1B;

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } mix_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes_v2_mix_size_if.sv
// ---------------------------------------------------------------------------
// aes_v2_mix_size_if
// Request/response bundle of the mix unit.
//   valid : request held high with stable operands until ready
//   rs1   : input column, byte 0 in bits 7:0
//   enc   : 1 = MixColumns, 0 = InvMixColumns
//   ready : rd carries the result this cycle
//   rd    : result column, byte 0 in bits 7:0
// master = issuing side, slave = mix unit.
// ---------------------------------------------------------------------------
interface aes_v2_mix_size_if;
    logic        valid;
    logic [31:0] rs1;
    logic        enc;
    logic        ready;
    logic [31:0] rd;

    modport master (output valid, rs1, enc, input ready, rd);
    modport slave  (input valid, rs1, enc, output ready, rd);
endinterface

// File: rtl/aes_v2_mix_size_mix_byte.sv
// ---------------------------------------------------------------------------
// aes_mix_byte
// Combinational single-byte column mix. Produces byte b0 of a column from
// a0..a3 (a0 is the byte at the output position, a1..a3 follow it).
//   a0_i..a3_i : input column bytes
//   enc_i      : 1 = forward (02,03,01,01), 0 = inverse (0E,0B,0D,09)
//   b0_o       : mixed byte
// One xtime chain (x2, x4, x8 per byte) serves both directions.
// ---------------------------------------------------------------------------
module aes_mix_byte
    import aes_v2_mix_size_pkg::*;
(
    input  logic [7:0] a0_i,
    input  logic [7:0] a1_i,
    input  logic [7:0] a2_i,
    input  logic [7:0] a3_i,
    input  logic       enc_i,
    output logic [7:0] b0_o
);

    logic [7:0] a  [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] fwd;
    logic [7:0] inv;

    assign a[0] = a0_i;
    assign a[1] = a1_i;
    assign a[2] = a2_i;
    assign a[3] = a3_i;

    for (genvar i = 0; i < 4; i++) begin : gen_chain
        assign x2[i] = xtime(a[i]);
        assign x4[i] = xtime(x2[i]);
        assign x8[i] = xtime(x4[i]);
    end

    // 02.a0 ^ 03.a1 ^ a2 ^ a3
    assign fwd = x2[0] ^ x2[1] ^ a[1] ^ a[2] ^ a[3];
    // 0E = 8+4+2, 0B = 8+2+1, 0D = 8+4+1, 09 = 8+1
    assign inv = (x8[0] ^ x4[0] ^ x2[0])
               ^ (x8[1] ^ x2[1] ^ a[1])
               ^ (x8[2] ^ x4[2] ^ a[2])
               ^ (x8[3] ^ a[3]);

    assign b0_o = enc_i ? fwd : inv;

endmodule

// File: rtl/aes_v2_mix_size.sv
// ---------------------------------------------------------------------------
// aes_v2_mix_size
// AES MixColumns / InvMixColumns on one state column.
//   g_clk    : clock, rising edge
//   g_resetn : asynchronous active-low reset
//   bus      : slave side of aes_v2_mix_size_if (valid/rs1/enc in, ready/rd out)
// FAST=0: one byte datapath, one output byte per cycle, ready on the 4th
//         cycle of a held valid. FAST=1: four datapaths, ready = valid.
// ---------------------------------------------------------------------------
module aes_v2_mix_size
    import aes_v2_mix_size_pkg::*;
#(
    parameter bit FAST = 1'b0
) (
    input  logic                 g_clk,
    input  logic                 g_resetn,
    aes_v2_mix_size_if.slave     bus
);

    // Valid is masked by reset so nothing reports ready, and the datapath
    // input is zeroed while idle so it does not toggle.
    logic        vld_m;
    logic [31:0] col_m;

    assign vld_m = bus.valid & g_resetn;
    assign col_m = vld_m ? bus.rs1 : 32'h0;

    if (FAST == 1'b0) begin : gen_slow
        mix_state_t  fsm_q, fsm_d;
        logic [7:0]  b0_q, b1_q, b2_q;
        logic [31:0] col_rot;
        logic [7:0]  mix_out;

        // State Sk feeds the column rotated right by k bytes, giving b_k.
        always_comb begin
            col_rot = col_m;
            case (fsm_q)
                S0:      col_rot = col_m;
                S1:      col_rot = {col_m[7:0],  col_m[31:8]};
                S2:      col_rot = {col_m[15:0], col_m[31:16]};
                default: col_rot = {col_m[23:0], col_m[31:24]};
            endcase
        end

        aes_mix_byte u_mix (
            .a0_i  (col_rot[7:0]),
            .a1_i  (col_rot[15:8]),
            .a2_i  (col_rot[23:16]),
            .a3_i  (col_rot[31:24]),
            .enc_i (bus.enc),
            .b0_o  (mix_out)
        );

        // Dropping valid in any state aborts back to S0.
        always_comb begin
            fsm_d = S0;
            if (vld_m) begin
                case (fsm_q)
                    S0:      fsm_d = S1;
                    S1:      fsm_d = S2;
                    S2:      fsm_d = S3;
                    default: fsm_d = S0;
                endcase
            end
        end

        always_ff @(posedge g_clk or negedge g_resetn) begin
            if (!g_resetn) begin
                fsm_q <= S0;
                b0_q  <= 8'h00;
                b1_q  <= 8'h00;
                b2_q  <= 8'h00;
            end else begin
                fsm_q <= fsm_d;
                if (vld_m) begin
                    case (fsm_q)
                        S0:      b0_q <= mix_out;
                        S1:      b1_q <= mix_out;
                        S2:      b2_q <= mix_out;
                        default: ;
                    endcase
                end
            end
        end

        assign bus.ready = vld_m && (fsm_q == S3);
        assign bus.rd    = {mix_out, b2_q, b1_q, b0_q};
    end else begin : gen_fast
        for (genvar k = 0; k < 4; k++) begin : gen_lane
            aes_mix_byte u_mix (
                .a0_i  (col_m[8*k +: 8]),
                .a1_i  (col_m[8*((k+1)%4) +: 8]),
                .a2_i  (col_m[8*((k+2)%4) +: 8]),
                .a3_i  (col_m[8*((k+3)%4) +: 8]),
                .enc_i (bus.enc),
                .b0_o  (bus.rd[8*k +: 8])
            );
        end

        assign bus.ready = vld_m;
    end

endmodule

// File: tb/tb_aes_v2_mix_size.sv
// ---------------------------------------------------------------------------
// tb_aes_v2_mix_size
// Bench for aes_v2_mix_size: a FAST=0 and a FAST=1 instance driven with the
// same requests, directed column vectors with known results, and random
// vectors on the single-cycle build against a GF(2^8) reference model.
// ---------------------------------------------------------------------------
module tb_aes_v2_mix_size;

    logic g_clk;
    logic g_resetn;
    int   errors = 0;
    int   checks = 0;

    aes_v2_mix_size_if if_s ();
    aes_v2_mix_size_if if_f ();

    aes_v2_mix_size #(.FAST(1'b0)) dut_slow (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .bus      (if_s.slave)
    );

    aes_v2_mix_size #(.FAST(1'b1)) dut_fast (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .bus      (if_f.slave)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    // Reference: generic shift-and-add multiply, full coefficient matrix.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [31:0] mix_ref(input logic [31:0] col, input logic e);
        logic [7:0]  c [4];
        logic [7:0]  a [4];
        logic [7:0]  b;
        logic [31:0] r;
        if (e) begin
            c[0] = 8'h02; c[1] = 8'h03; c[2] = 8'h01; c[3] = 8'h01;
        end else begin
            c[0] = 8'h0E; c[1] = 8'h0B; c[2] = 8'h0D; c[3] = 8'h09;
        end
        for (int i = 0; i < 4; i++) a[i] = col[8*i +: 8];
        r = 32'h0;
        for (int i = 0; i < 4; i++) begin
            b = 8'h00;
            for (int j = 0; j < 4; j++) b = b ^ gmul(a[(i+j)%4], c[j]);
            r[8*i +: 8] = b;
        end
        return r;
    endfunction

    task automatic drive(input logic v, input logic [31:0] r, input logic e);
        if_s.valid = v; if_s.rs1 = r; if_s.enc = e;
        if_f.valid = v; if_f.rs1 = r; if_f.enc = e;
    endtask

    task automatic test_reset;
        g_resetn = 1'b0;
        drive(1'b1, 32'h455313DB, 1'b1);
        #3;
        checks++;
        if (if_s.ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready actual=%b required=0", if_s.ready);
        end
        checks++;
        if (if_s.rd !== 32'h0) begin
            errors++; $display("FAIL reset_rd actual=%h required=00000000", if_s.rd);
        end
        checks++;
        if (if_f.ready !== 1'b0) begin
            errors++; $display("FAIL reset_fast_ready actual=%b required=0", if_f.ready);
        end
        @(posedge g_clk); #1;
        checks++;
        if (2'(dut_slow.gen_slow.fsm_q) !== 2'd0) begin
            errors++; $display("FAIL reset_fsm actual=%0d required=0", dut_slow.gen_slow.fsm_q);
        end
        drive(1'b0, 32'h0, 1'b1);
        g_resetn = 1'b1;
        @(negedge g_clk);
        checks++;
        if (if_s.ready !== 1'b0) begin
            errors++; $display("FAIL idle_ready actual=%b required=0", if_s.ready);
        end
    endtask

    task automatic test_forward;
        logic exp_r;
        @(posedge g_clk); #1;
        drive(1'b1, 32'h455313DB, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) begin @(posedge g_clk); #1; end
            @(negedge g_clk);
            exp_r = (k == 4);
            checks++;
            if (if_s.ready !== exp_r) begin
                errors++; $display("FAIL fwd_ready cycle=%0d actual=%b required=%b", k, if_s.ready, exp_r);
            end
        end
        checks++;
        if (if_s.rd !== 32'hBCA14D8E) begin
            errors++; $display("FAIL fwd_rd actual=%h required=BCA14D8E", if_s.rd);
        end
        checks++;
        if (if_f.rd !== 32'hBCA14D8E) begin
            errors++; $display("FAIL fwd_fast_rd actual=%h required=BCA14D8E", if_f.rd);
        end
        @(posedge g_clk); #1;
        drive(1'b0, 32'h455313DB, 1'b1);
        @(negedge g_clk);
        checks++;
        if (if_s.ready !== 1'b0) begin
            errors++; $display("FAIL fwd_ready cycle=5 actual=%b required=0", if_s.ready);
        end
    endtask

    task automatic test_inverse;
        logic [31:0] ins  [2];
        logic [31:0] outs [2];
        logic        exp_r;
        ins[0] = 32'hBCA14D8E; outs[0] = 32'h455313DB;
        ins[1] = 32'h9D58DC9F; outs[1] = 32'h5C220AF2;
        for (int t = 0; t < 2; t++) begin
            @(posedge g_clk); #1;
            drive(1'b1, ins[t], 1'b0);
            for (int k = 1; k <= 4; k++) begin
                if (k > 1) begin @(posedge g_clk); #1; end
                @(negedge g_clk);
                exp_r = (k == 4);
                checks++;
                if (if_s.ready !== exp_r) begin
                    errors++; $display("FAIL inv_ready op=%0d cycle=%0d actual=%b required=%b", t, k, if_s.ready, exp_r);
                end
            end
            checks++;
            if (if_s.rd !== outs[t]) begin
                errors++; $display("FAIL inv_rd op=%0d actual=%h required=%h", t, if_s.rd, outs[t]);
            end
            checks++;
            if (if_f.rd !== outs[t]) begin
                errors++; $display("FAIL inv_fast_rd op=%0d actual=%h required=%h", t, if_f.rd, outs[t]);
            end
            @(posedge g_clk); #1;
            drive(1'b0, 32'h0, 1'b0);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] ins  [3];
        logic [31:0] outs [3];
        logic        exp_r;
        ins[0] = 32'h01010101; outs[0] = 32'h01010101;
        ins[1] = 32'hC6C6C6C6; outs[1] = 32'hC6C6C6C6;
        ins[2] = 32'h5C220AF2; outs[2] = 32'h9D58DC9F;
        for (int c = 1; c <= 12; c++) begin
            @(posedge g_clk); #1;
            if ((c % 4) == 1) drive(1'b1, ins[(c-1)/4], 1'b1);
            @(negedge g_clk);
            exp_r = ((c % 4) == 0);
            checks++;
            if (if_s.ready !== exp_r) begin
                errors++; $display("FAIL b2b_ready cycle=%0d actual=%b required=%b", c, if_s.ready, exp_r);
            end
            if (exp_r) begin
                checks++;
                if (if_s.rd !== outs[(c-1)/4]) begin
                    errors++; $display("FAIL b2b_rd cycle=%0d actual=%h required=%h", c, if_s.rd, outs[(c-1)/4]);
                end
            end
        end
        @(posedge g_clk); #1;
        drive(1'b0, 32'h0, 1'b1);
    endtask

    task automatic test_abort;
        logic exp_r;
        @(posedge g_clk); #1;
        drive(1'b1, 32'h12345678, 1'b1);
        @(posedge g_clk); #1;
        @(posedge g_clk); #1;
        drive(1'b0, 32'h12345678, 1'b1);
        @(negedge g_clk);
        checks++;
        if (if_s.ready !== 1'b0) begin
            errors++; $display("FAIL abort_ready actual=%b required=0", if_s.ready);
        end
        @(posedge g_clk); #1;
        checks++;
        if (2'(dut_slow.gen_slow.fsm_q) !== 2'd0) begin
            errors++; $display("FAIL abort_fsm actual=%0d required=0", dut_slow.gen_slow.fsm_q);
        end
        drive(1'b1, 32'h455313DB, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) begin @(posedge g_clk); #1; end
            @(negedge g_clk);
            exp_r = (k == 4);
            checks++;
            if (if_s.ready !== exp_r) begin
                errors++; $display("FAIL abort_ready cycle=%0d actual=%b required=%b", k, if_s.ready, exp_r);
            end
        end
        checks++;
        if (if_s.rd !== 32'hBCA14D8E) begin
            errors++; $display("FAIL abort_rd actual=%h required=BCA14D8E", if_s.rd);
        end
        @(posedge g_clk); #1;
        drive(1'b0, 32'h0, 1'b1);
    endtask

    task automatic test_async_reset;
        logic exp_r;
        @(posedge g_clk); #1;
        drive(1'b1, 32'h455313DB, 1'b1);
        @(posedge g_clk); #2;
        g_resetn = 1'b0;
        #1;
        checks++;
        if (2'(dut_slow.gen_slow.fsm_q) !== 2'd0) begin
            errors++; $display("FAIL areset_fsm actual=%0d required=0", dut_slow.gen_slow.fsm_q);
        end
        checks++;
        if (if_s.ready !== 1'b0) begin
            errors++; $display("FAIL areset_ready actual=%b required=0", if_s.ready);
        end
        checks++;
        if (if_s.rd !== 32'h0) begin
            errors++; $display("FAIL areset_rd actual=%h required=00000000", if_s.rd);
        end
        @(posedge g_clk); #1;
        g_resetn = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) begin @(posedge g_clk); #1; end
            @(negedge g_clk);
            exp_r = (k == 4);
            checks++;
            if (if_s.ready !== exp_r) begin
                errors++; $display("FAIL areset_ready cycle=%0d actual=%b required=%b", k, if_s.ready, exp_r);
            end
        end
        checks++;
        if (if_s.rd !== 32'hBCA14D8E) begin
            errors++; $display("FAIL areset_rd_after actual=%h required=BCA14D8E", if_s.rd);
        end
        @(posedge g_clk); #1;
        drive(1'b0, 32'h0, 1'b1);
    endtask

    task automatic test_fast;
        logic        v;
        logic [31:0] r;
        logic        e;
        logic [31:0] exp_rd;
        for (int n = 0; n < 1000; n++) begin
            @(posedge g_clk); #1;
            v = ($urandom_range(0, 3) != 0);
            r = $urandom;
            e = 1'($urandom_range(0, 1));
            drive(v, r, e);
            #2;
            checks++;
            if (if_f.ready !== v) begin
                errors++; $display("FAIL fast_ready n=%0d actual=%b required=%b", n, if_f.ready, v);
            end
            if (v) begin
                exp_rd = mix_ref(r, e);
                checks++;
                if (if_f.rd !== exp_rd) begin
                    errors++; $display("FAIL fast_rd n=%0d rs1=%h enc=%b actual=%h required=%h", n, r, e, if_f.rd, exp_rd);
                end
            end
        end
        @(posedge g_clk); #1;
        drive(1'b0, 32'h0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_forward();
        test_inverse();
        test_back_to_back();
        test_abort();
        test_async_reset();
        test_fast();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
